// File: rtl/fma_acc_pkg.sv
// Shared types and helpers for the FMA pair accumulator: FSM states,
// accumulator width derivation and signed saturating narrowing.
package fma_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic               clipped;
    logic signed [63:0] value;
  } narrow_t;

  // Worst-case growth of MAX_LEN sums of 2*BW-bit signed terms.
  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned max_len);
    return 2 * bw + $clog2(max_len);
  endfunction

  // Clamp a signed value into the out_w-bit two's-complement range.
  function automatic narrow_t sat_narrow(input logic signed [63:0] value, input int unsigned out_w);
    narrow_t            r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.clipped = 1'b0;
    r.value   = value;
    if (value > hi) begin
      r.clipped = 1'b1;
      r.value   = hi;
    end else if (value < lo) begin
      r.clipped = 1'b1;
      r.value   = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fma_acc_lane.sv
// One accumulator lane: ACC_W signed accumulator with clear/load/add control and
// registered narrowing to OUT_W (saturating when FMA_ACC_SAT_EN is defined, else wrap).
module fma_acc_lane
  import fma_acc_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned OUT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             add_i,
  input  logic [IN_W-1:0]  res_i,
  output logic [OUT_W-1:0] sum_o
`ifdef FMA_ACC_SAT_EN
  ,
  output logic             clip_c
`endif
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] res_ext;
  logic        [OUT_W-1:0] sum_d;

  assign res_ext = ACC_W'($signed(res_i));

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = res_ext;
    end else if (add_i) begin
      acc_d = acc_q + res_ext;
    end
  end

`ifdef FMA_ACC_SAT_EN
  narrow_t nar;

  always_comb begin
    nar    = sat_narrow(64'(acc_d), OUT_W);
    sum_d  = OUT_W'(nar.value);
    clip_c = nar.clipped;
  end
`else
  always_comb begin
    sum_d = OUT_W'(acc_d);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sum_o <= '0;
    end else begin
      acc_q <= acc_d;
      sum_o <= sum_d;
    end
  end

endmodule

// File: rtl/fma_pair_accum.sv
// Frame accumulator for the dual-lane FMA stage: sums res_c/res_d over a frame and
// holds the pair of sums until taken. Optional saturation via FMA_ACC_SAT_EN.
module fma_pair_accum
  import fma_acc_pkg::*;
#(
  parameter  int unsigned BW      = 8,
  parameter  int unsigned MAX_LEN = 16,
  parameter  int unsigned OUT_W   = 20,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [2*BW-1:0]  res_c,
  input  logic [2*BW-1:0]  res_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] sum_c,
  output logic [OUT_W-1:0] sum_d,
  output logic [CNT_W-1:0] sum_cnt
`ifdef FMA_ACC_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int unsigned ACC_W = acc_width(BW, MAX_LEN);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q;
  logic             accept;
  logic             lane_clr, lane_load, lane_add;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_clr  = 1'b0;
    lane_load = 1'b0;
    lane_add  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lane_load = 1'b1;
          cnt_d     = CNT_W'(1);
          state_d   = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        // Reaching MAX_LEN closes the frame regardless of in_last.
        if (accept) begin
          lane_add = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (in_last || (cnt_d == CNT_W'(MAX_LEN))) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          lane_clr = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_cnt   = cnt_q;

`ifdef FMA_ACC_SAT_EN
  logic clip_lc, clip_ld, sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= (state_d == HOLD) & (clip_lc | clip_ld);
    end
  end

  assign sat_flag = sat_q;
`endif

  fma_acc_lane #(
    .IN_W (2 * BW),
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_lane_c (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (lane_clr),
    .load_i(lane_load),
    .add_i (lane_add),
    .res_i (res_c),
    .sum_o (sum_c)
`ifdef FMA_ACC_SAT_EN
    ,
    .clip_c(clip_lc)
`endif
  );

  fma_acc_lane #(
    .IN_W (2 * BW),
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_lane_d (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (lane_clr),
    .load_i(lane_load),
    .add_i (lane_add),
    .res_i (res_d),
    .sum_o (sum_d)
`ifdef FMA_ACC_SAT_EN
    ,
    .clip_c(clip_ld)
`endif
  );

endmodule

// File: tb/tb_fma_pair_accum.sv
// Directed + random bench for fma_pair_accum (BW=8, MAX_LEN=4, OUT_W=18) with a
// second OUT_W=16 instance sharing the stimulus for the narrowing case.
module tb_fma_pair_accum;

  localparam int unsigned BW      = 8;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  logic        clk, rst_n;
  logic        in_valid, in_last, out_ready;
  logic [15:0] res_c, res_d;
  logic        in_ready, out_valid, in_ready16, out_valid16;
  logic [17:0] sum_c, sum_d;
  logic [15:0] sum_c16, sum_d16;
  logic [CNT_W-1:0] sum_cnt, sum_cnt16;
`ifdef FMA_ACC_SAT_EN
  logic        sat_flag, sat_flag16;
`endif

  fma_pair_accum #(.BW(BW), .MAX_LEN(MAX_LEN), .OUT_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .res_c(res_c), .res_d(res_d), .out_valid(out_valid), .out_ready(out_ready),
    .sum_c(sum_c), .sum_d(sum_d), .sum_cnt(sum_cnt)
`ifdef FMA_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  fma_pair_accum #(.BW(BW), .MAX_LEN(MAX_LEN), .OUT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last),
    .res_c(res_c), .res_d(res_d), .out_valid(out_valid16), .out_ready(out_ready),
    .sum_c(sum_c16), .sum_d(sum_d16), .sum_cnt(sum_cnt16)
`ifdef FMA_ACC_SAT_EN
    , .sat_flag(sat_flag16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int c; int d; int n;} exp_t;
  exp_t q[$];
  int   m_c, m_d, m_n;
  int   n_pass, n_total;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap18(input int v);
    logic signed [17:0] t;
    t = v[17:0];
    return int'(t);
  endfunction

  // One cycle, entered and left at a falling edge; model tracks handshakes.
  task automatic step(input bit v, input logic [15:0] c, input logic [15:0] d,
                      input bit last, input bit ordy);
    exp_t e;
    in_valid  = v;
    res_c     = c;
    res_d     = d;
    in_last   = last;
    out_ready = ordy;
    if (out_valid === 1'b1 && ordy) begin
      chk("frame_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sum_c", $signed(sum_c), wrap18(e.c));
        chk("sum_d", $signed(sum_d), wrap18(e.d));
        chk("sum_cnt", sum_cnt, e.n);
      end
    end
    if (v && in_ready === 1'b1) begin
      m_c += $signed(c);
      m_d += $signed(d);
      m_n++;
      if (last || m_n == MAX_LEN) begin
        q.push_back('{m_c, m_d, m_n});
        m_c = 0; m_d = 0; m_n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] c, input logic [15:0] d, input bit last, input bit ordy);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      done = (in_ready === 1'b1);
      step(1'b1, c, d, last, ordy);
    end
    chk("send_accepted", int'(done), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() > 0 || out_valid === 1'b1); i++) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum_c"}, $signed(sum_c), 0);
    chk({tag, "_sum_d"}, $signed(sum_d), 0);
    chk({tag, "_sum_cnt"}, sum_cnt, 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    m_c = 0; m_d = 0; m_n = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    res_c = '0; res_d = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: 3-beat frame, one cycle of back-pressure on the input, then IDLE.
    send(16'd100, 16'd1, 1'b0, 1'b1);
    send(-16'sd50, 16'd2, 1'b0, 1'b1);
    send(16'd7, 16'd3, 1'b1, 1'b1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready_hold", in_ready, 0);
    chk("t1_sum_c", $signed(sum_c), 57);
    chk("t1_sum_d", $signed(sum_d), 6);
    chk("t1_sum_cnt", sum_cnt, 3);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_out_valid_clr", out_valid, 0);

    // Test 2: six beats, no in_last; auto-close at MAX_LEN, second frame stays open.
    for (int i = 0; i < 6; i++) send(16'd1, 16'd1, 1'b0, 1'b1);
    chk("t2_open_out_valid", out_valid, 0);
    chk("t2_open_in_ready", in_ready, 1);
    chk("t2_first_popped", q.size(), 0);
    send(16'd1, 16'd1, 1'b1, 1'b1);
    chk("t2_sum_c", $signed(sum_c), 3);
    chk("t2_sum_cnt", sum_cnt, 3);
    drain();

    // Test 3: single extreme beat held with out_ready low.
    send(16'h8000, 16'h7fff, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_out_valid", out_valid, 1);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_sum_c", $signed(sum_c), -32768);
      chk("t3_sum_d", $signed(sum_d), 32767);
      chk("t3_sum_cnt", sum_cnt, 1);
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    end
    drain();

    // Test 4: 4 x 32767 overflows the 16-bit output instance.
    for (int i = 0; i < 4; i++) send(16'h7fff, 16'd0, 1'b0, 1'b0);
    chk("t4_out_valid16", out_valid16, 1);
`ifdef FMA_ACC_SAT_EN
    chk("t4_sum_c16_sat", $signed(sum_c16), 32767);
    chk("t4_sat_flag16", sat_flag16, 1);
    chk("t4_sat_flag18", sat_flag, 0);
`else
    chk("t4_sum_c16_wrap", $signed(sum_c16), -4);
`endif
    chk("t4_sum_c18", $signed(sum_c), 131068);
    drain();

    // Test 5: asynchronous reset mid-frame and mid-hold.
    send(16'd40, 16'd41, 1'b0, 1'b1);
    send(16'd50, 16'd51, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid_frame");
    m_c = 0; m_d = 0; m_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd9, 16'd9, 1'b1, 1'b0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("t5_hold_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid_hold");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd5, -16'sd2, 1'b0, 1'b1);
    send(16'd6, 16'd3, 1'b1, 1'b1);
    chk("t5_sum_c_new", $signed(sum_c), 11);
    chk("t5_sum_d_new", $signed(sum_d), 1);
    chk("t5_sum_cnt_new", sum_cnt, 2);
    drain();

    // Test 6: random valid/ready gaps against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    if (m_n > 0) send(16'd0, 16'd0, 1'b1, 1'b1);
    drain();
    chk("t6_model_idle", m_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
